// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO feeding a start/done ALU, one response per command
// IDLE pops a command, BUSY waits for done or timeout, DRAIN masks a stale done, RESP holds the answer.
module alu_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [7:0]             cmd_a,
   input  logic [7:0]             cmd_b,
   input  logic [2:0]             cmd_op,
   output logic [7:0]             alu_A,
   output logic [7:0]             alu_B,
   output logic [2:0]             alu_op,
   output logic                   alu_start,
   input  logic                   alu_done,
   input  logic [15:0]            alu_result,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [15:0]            rsp_result,
   output logic [2:0]             rsp_op,
   output logic                   rsp_err,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BUSY  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [18:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_a;
   logic [7:0]    r_b;
   logic [2:0]    r_op;
   logic [15:0]   r_rsp_result;
   logic [2:0]    r_rsp_op;
   logic          r_rsp_err;

   logic          w_push;
   logic          w_pop;
   logic [18:0]   w_head;

   assign cmd_ready  = !reset && (r_count < (AW + 1)'(DEPTH));
   assign w_push     = cmd_valid && cmd_ready;
   assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
   assign w_head     = r_mem[r_rd_ptr];

   assign alu_A      = r_a;
   assign alu_B      = r_b;
   assign alu_op     = r_op;
   assign alu_start  = (r_state == S_BUSY);
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_result = r_rsp_result;
   assign rsp_op     = r_rsp_op;
   assign rsp_err    = r_rsp_err;
   assign busy       = (r_state != S_IDLE);
   assign fifo_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= '0;
         r_rsp_result <= '0;
         r_rsp_op     <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  {r_op, r_a, r_b} <= w_head;
                  r_rsp_op         <= w_head[18:16];
                  r_rsp_result     <= '0;
                  r_rsp_err        <= 1'b0;
                  r_cnt            <= '0;
                  r_state          <= (w_head[18:16] == 3'b000) ? S_RESP : S_BUSY;
               end
            end
            S_BUSY: begin
               if (alu_done) begin
                  r_rsp_result <= alu_result;
                  r_rsp_err    <= 1'b0;
                  r_state      <= S_DRAIN;
               end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  // this is the TIMEOUT-th cycle with start high and still no done
                  r_rsp_result <= '0;
                  r_rsp_err    <= 1'b1;
                  r_state      <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer with a behavioural start/done ALU
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  cmd_op;
   logic [7:0]  alu_A;
   logic [7:0]  alu_B;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
   logic        rsp_err;
   logic        busy;
   logic [2:0]  fifo_count;

   alu_cmd_sequencer #(.DEPTH(4), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
      .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
      .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] res;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   hs[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   n_viol  = 0;

   function automatic logic [15:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'b000:  return 16'd0;
         3'b001:  return {8'd0, a} + {8'd0, b};
         3'b010:  return {8'd0, a & b};
         3'b011:  return {8'd0, a ^ b};
         default: return {8'd0, a} * {8'd0, b};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ALU model: add/and/xor done in the 1st start cycle, mult in the 4th; done lingers one extra cycle
   logic [2:0] alu_cnt;
   logic       r_stale;
   logic       done_kill;
   logic       stray;
   logic       w_real_done;
   always @(posedge clk) begin
      alu_cnt <= alu_start ? alu_cnt + 3'd1 : 3'd0;
      r_stale <= w_real_done;
   end
   assign w_real_done = alu_start && !done_kill && (alu_cnt == (alu_op[2] ? 3'd3 : 3'd0));
   assign alu_done    = w_real_done || r_stale || (stray && !alu_start);
   assign alu_result  = model(alu_op, alu_A, alu_B);

   always @(posedge clk) cyc <= cyc + 1;

   exp_t       mon_e;
   logic       prev_start = 1'b0;
   logic [18:0] prev_cmd = '0;
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("rsp_result", rsp_result, mon_e.res);
            check("rsp_op", rsp_op, mon_e.op);
            check("rsp_err", rsp_err, mon_e.err);
            hs.push_back(cyc);
         end
      end
      if (prev_start && alu_start && ({alu_op, alu_A, alu_B} != prev_cmd)) n_viol++;
      prev_start = alu_start;
      prev_cmd   = {alu_op, alu_A, alu_B};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] res, input logic err);
      logic got;
      exp_t e;
      got = 1'b0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clk);
         if (cmd_ready) got = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      if (got) begin
         e.op = op; e.res = res; e.err = err;
         sb.push_back(e);
      end else begin
         check("push_accept", 32'(got), 32'd1);
      end
   endtask

   task automatic measure(output int lat, output int first_start, output int n_start);
      int n;
      n = 0; lat = -1; first_start = 0; n_start = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         n++;
         if (alu_start) begin
            n_start++;
            if (first_start == 0) first_start = n;
         end
         if (rsp_valid) begin
            lat = n;
            break;
         end
      end
      tick();
   endtask

   task automatic wait_drain(input string tag);
      for (int k = 0; k < 400 && (sb.size() != 0 || busy); k++) tick();
      check(tag, 32'(sb.size() == 0 && !busy), 32'd1);
   endtask

   int lat, fs, ns, acc;
   logic [2:0] bp_ops [6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
      rsp_ready = 1'b1; done_kill = 1'b0; stray = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_busy", busy, 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", cmd_ready, 1);
      check("post_rst_outputs", {alu_start, rsp_valid, rsp_err, alu_A, alu_B, alu_op, rsp_result, rsp_op}, 0);
      tick();

      // add 3+4
      push(3'b001, 8'd3, 8'd4, 16'd7, 1'b0);
      measure(lat, fs, ns);
      check("add_latency", lat, 4);
      check("add_start_delay", fs, 2);
      wait_drain("add_drain");

      // mult 255*255
      push(3'b100, 8'd255, 8'd255, 16'hFE01, 1'b0);
      measure(lat, fs, ns);
      check("mult_latency", lat, 7);
      check("mult_start_cycles", ns, 4);
      wait_drain("mult_drain");

      // nop then xor with stray/stale done pulses around
      stray = 1'b1;
      push(3'b000, 8'h55, 8'hAA, 16'h0000, 1'b0);
      measure(lat, fs, ns);
      check("nop_latency", lat, 2);
      check("nop_no_start", ns, 0);
      push(3'b011, 8'hF0, 8'h0F, 16'h00FF, 1'b0);
      wait_drain("xor_drain");
      stray = 1'b0;

      // timeout
      done_kill = 1'b1;
      push(3'b010, 8'hFF, 8'h0F, 16'h0000, 1'b1);
      measure(lat, fs, ns);
      check("timeout_start_cycles", ns, 15);
      check("timeout_latency", lat, 18);
      wait_drain("timeout_drain");
      done_kill = 1'b0;

      // backpressure: 6 offered, 5 fit
      bp_ops = '{3'b001, 3'b010, 3'b011, 3'b000, 3'b111, 3'b110};
      rsp_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 12; k++) begin
         cmd_valid = (acc < 6);
         cmd_op = bp_ops[acc % 6];
         cmd_a  = 8'(acc * 17 + 5);
         cmd_b  = 8'(acc * 29 + 3);
         @(negedge clk);
         if (cmd_valid && cmd_ready) begin
            sb.push_back('{cmd_op, model(cmd_op, cmd_a, cmd_b), 1'b0});
            acc++;
         end
         tick();
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_accepted", acc, 5);
      check("bp_fifo_full", fifo_count, 4);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_rsp_held", rsp_valid, 1);
      tick();
      rsp_ready = 1'b1;
      wait_drain("bp_drain");

      // throughput
      hs.delete();
      for (int i = 0; i < 3; i++) push(3'b001, 8'(i + 1), 8'(i * 3), 16'(4 * i + 1), 1'b0);
      wait_drain("tp_add_drain");
      check("tp_add_count", hs.size(), 3);
      if (hs.size() == 3) begin
         check("tp_add_gap0", hs[1] - hs[0], 4);
         check("tp_add_gap1", hs[2] - hs[1], 4);
      end
      hs.delete();
      for (int i = 0; i < 2; i++) push(3'b101, 8'(i + 10), 8'd20, 16'(200 + 20 * i), 1'b0);
      wait_drain("tp_mult_drain");
      check("tp_mult_count", hs.size(), 2);
      if (hs.size() == 2) check("tp_mult_gap", hs[1] - hs[0], 7);

      // reset mid-BUSY with two queued
      hs.delete();
      push(3'b100, 8'd12, 8'd34, 16'd408, 1'b0);
      push(3'b001, 8'd1, 8'd2, 16'd3, 1'b0);
      push(3'b011, 8'd5, 8'd6, 16'd3, 1'b0);
      @(negedge clk);
      check("mid_busy", {busy, alu_start, fifo_count}, {1'b1, 1'b1, 3'd2});
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      check("rst_mid_alu", {alu_start, alu_A, alu_B, alu_op}, 0);
      check("rst_mid_rsp", {rsp_valid, rsp_result, rsp_op, rsp_err}, 0);
      check("rst_mid_busy_fifo", {busy, fifo_count, cmd_ready}, 0);
      sb.delete();
      tick();
      reset = 1'b0;
      repeat (30) tick();
      check("rst_no_responses", hs.size(), 0);
      check("rst_idle", {busy, fifo_count}, 0);

      check("start_gap_violations", n_viol, 0);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
